// File: rtl/fma_operand_sched.sv
// fma_operand_sched: steps an A/B/C operand triple through one shared decoder,
// then issues the decoded bundle with the FMA special-case flags.
module fma_operand_sched #(
    parameter int CNT_W    = 16,
    parameter int DEC_PIPE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      op_a,
    input  logic [63:0]      op_b,
    input  logic [63:0]      op_c,
    input  logic [1:0]       precision,
    output logic [63:0]      dec_in,
    output logic [1:0]       dec_precision,
    output logic             dec_en,
    input  logic             dec_sign,
    input  logic [10:0]      dec_exp,
    input  logic [52:0]      dec_mantissa,
    input  logic [3:0]       dec_class,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_sign,
    output logic [32:0]      out_exp,
    output logic [158:0]     out_mant,
    output logic [11:0]      out_class,
    output logic [1:0]       out_precision,
    output logic             out_invalid,
    output logic             out_inf,
    output logic             out_inf_sign,
    output logic [CNT_W-1:0] ops_issued
);
    typedef enum logic [2:0] {IDLE, DEC_A, DEC_B, DEC_C, ISSUE} state_t;
    state_t      r_state;
    logic        r_ph;
    logic [63:0] r_a, r_b, r_c;
    logic        w_dec, w_cap, w_p_inf, w_p_sign, w_invalid;
    logic [1:0]  w_idx;
    logic [3:0]  w_ca, w_cb, w_cc;
    assign w_dec         = r_state inside {DEC_A, DEC_B, DEC_C};
    // with a registered decoder the second cycle of each DEC state is the capture cycle
    assign w_cap         = w_dec && (DEC_PIPE == 0 || r_ph);
    assign w_idx         = r_state[1:0] - 2'd1;
    assign in_ready      = r_state == IDLE;
    assign dec_en        = w_dec;
    assign dec_precision = w_dec ? out_precision : 2'b00;
    assign dec_in        = r_state == DEC_A ? r_a :
                           r_state == DEC_B ? r_b :
                           r_state == DEC_C ? r_c : 64'd0;
    // class nibble is {nan, inf, norm, zero}
    assign w_ca      = out_class[3:0];
    assign w_cb      = out_class[7:4];
    assign w_cc      = out_class[11:8];
    assign w_p_inf   = w_ca[2] | w_cb[2];
    assign w_p_sign  = out_sign[0] ^ out_sign[1];
    assign w_invalid = w_ca[3] | w_cb[3] | w_cc[3] | (w_ca[2] & w_cb[0]) | (w_ca[0] & w_cb[2]) |
                       (w_p_inf & w_cc[2] & (w_p_sign != out_sign[2]));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ph          <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            out_valid     <= 1'b0;
            out_sign      <= '0;
            out_exp       <= '0;
            out_mant      <= '0;
            out_class     <= '0;
            out_precision <= '0;
            out_invalid   <= 1'b0;
            out_inf       <= 1'b0;
            out_inf_sign  <= 1'b0;
            ops_issued    <= '0;
        end else begin
            if (w_cap) begin
                out_sign[w_idx]             <= dec_sign;
                out_exp[w_idx*11 +: 11]     <= dec_exp;
                out_mant[w_idx*53 +: 53]    <= dec_mantissa;
                out_class[w_idx*4 +: 4]     <= dec_class;
            end
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a           <= op_a;
                    r_b           <= op_b;
                    r_c           <= op_c;
                    out_precision <= precision;
                    r_state       <= DEC_A;
                end
                DEC_A, DEC_B, DEC_C: begin
                    r_ph <= !w_cap;
                    if (w_cap) r_state <= state_t'(r_state + 3'd1);
                end
                ISSUE: if (!out_valid) begin
                    out_valid    <= 1'b1;
                    out_invalid  <= w_invalid;
                    out_inf      <= !w_invalid & (w_p_inf | w_cc[2]);
                    out_inf_sign <= w_p_inf ? w_p_sign : out_sign[2];
                end else if (out_ready) begin
                    out_valid  <= 1'b0;
                    ops_issued <= ops_issued + CNT_W'(1);
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fma_operand_sched.sv
// tb_fma_operand_sched: directed checks of sequencing, flags, backpressure, reset and counter wrap.
module tb_fma_operand_sched;
    logic         clk = 0, rst = 0, in_valid = 0, in_ready, out_ready = 1;
    logic [63:0]  op_a = 0, op_b = 0, op_c = 0, dec_in;
    logic [1:0]   precision = 0, dec_precision, out_precision;
    logic         dec_en, dec_sign, out_valid, out_invalid, out_inf, out_inf_sign;
    logic [10:0]  dec_exp;
    logic [52:0]  dec_mantissa;
    logic [3:0]   dec_class, ops_issued;
    logic [2:0]   out_sign;
    logic [32:0]  out_exp;
    logic [158:0] out_mant;
    logic [11:0]  out_class;
    int n_checks = 0, n_fail = 0;
    logic [3:0] exp_ops = 0;

    fma_operand_sched #(.CNT_W(4), .DEC_PIPE(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .precision(precision),
        .dec_in(dec_in), .dec_precision(dec_precision), .dec_en(dec_en),
        .dec_sign(dec_sign), .dec_exp(dec_exp), .dec_mantissa(dec_mantissa), .dec_class(dec_class),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
        .out_mant(out_mant), .out_class(out_class), .out_precision(out_precision),
        .out_invalid(out_invalid), .out_inf(out_inf), .out_inf_sign(out_inf_sign),
        .ops_issued(ops_issued)
    );

    always #5 clk = ~clk;

    // reference combinational decoder standing in for the shared datapath decoder
    logic        d_s;
    logic [10:0] d_e, d_emax;
    logic [51:0] d_f;
    always_comb begin
        case (dec_precision)
            2'b01:   begin d_s = dec_in[15]; d_e = {6'd0, dec_in[14:10]}; d_f = {dec_in[9:0], 42'd0};  d_emax = 11'd31;   end
            2'b10:   begin d_s = dec_in[31]; d_e = {3'd0, dec_in[30:23]}; d_f = {dec_in[22:0], 29'd0}; d_emax = 11'd255;  end
            default: begin d_s = dec_in[63]; d_e = dec_in[62:52];         d_f = dec_in[51:0];          d_emax = 11'd2047; end
        endcase
        dec_sign     = d_s;
        dec_exp      = d_e;
        dec_mantissa = {d_e != 0, d_f};
        dec_class    = {d_e == d_emax && d_f != 0, d_e == d_emax && d_f == 0,
                        d_e != 0 && d_e != d_emax, d_e == 0 && d_f == 0};
    end

    task automatic send(input logic [63:0] a, b, c, input logic [1:0] p);
        @(negedge clk);
        in_valid = 1; op_a = a; op_b = b; op_c = c; precision = p;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end while (n < 20);
    endtask

    task automatic test_reset;
        #2 rst = 1;
        #2;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (dec_en !== 1'b0 || ops_issued !== 4'd0) begin n_fail++; $display("FAIL reset_dec_ops: got %b %h want 0 0", dec_en, ops_issued); end
        n_checks++; if (out_exp !== 33'd0 || out_class !== 12'd0 || out_invalid !== 1'b0 || out_inf !== 1'b0) begin
            n_fail++; $display("FAIL reset_bus: got %h %h %b %b want zeros", out_exp, out_class, out_invalid, out_inf); end
        @(negedge clk) rst = 0;
    endtask

    task automatic test_double;
        send(64'h3FF0000000000000, 64'h4000000000000000, 64'h0, 2'b00);
        @(negedge clk);
        n_checks++; if (dec_en !== 1'b1 || dec_in !== 64'h3FF0000000000000 || dec_precision !== 2'b00) begin
            n_fail++; $display("FAIL dec_a: got en=%b in=%h want 1 3ff0000000000000", dec_en, dec_in); end
        @(negedge clk);
        n_checks++; if (dec_in !== 64'h4000000000000000) begin n_fail++; $display("FAIL dec_b: got %h want 4000000000000000", dec_in); end
        @(negedge clk);
        n_checks++; if (dec_en !== 1'b1 || dec_in !== 64'h0) begin n_fail++; $display("FAIL dec_c: got en=%b in=%h want 1 0", dec_en, dec_in); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || dec_en !== 1'b0 || dec_in !== 64'h0) begin
            n_fail++; $display("FAIL early_valid: got v=%b en=%b in=%h want 0 0 0", out_valid, dec_en, dec_in); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency4: got %b want 1", out_valid); end
        n_checks++; if (out_exp !== {11'h000, 11'h400, 11'h3FF}) begin n_fail++; $display("FAIL dbl_exp: got %h want %h", out_exp, {11'h000, 11'h400, 11'h3FF}); end
        n_checks++; if (out_class !== {4'b0001, 4'b0010, 4'b0010}) begin n_fail++; $display("FAIL dbl_class: got %h want 122", out_class); end
        n_checks++; if (out_mant[52:0] !== 53'h10000000000000 || out_sign !== 3'b000) begin
            n_fail++; $display("FAIL dbl_mant: got %h %b want 10000000000000 000", out_mant[52:0], out_sign); end
        n_checks++; if (out_invalid !== 1'b0 || out_inf !== 1'b0) begin n_fail++; $display("FAIL dbl_flags: got %b %b want 0 0", out_invalid, out_inf); end
        @(posedge clk); #1 exp_ops++;
        n_checks++; if (ops_issued !== exp_ops || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL dbl_handoff: got ops=%h v=%b r=%b want %h 0 1", ops_issued, out_valid, in_ready, exp_ops); end
    endtask

    task automatic test_single;
        int n;
        send(64'h7F800000, 64'h0, 64'h3F800000, 2'b10);
        wait_valid(n);
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL sgl_latency: got %0d want 4", n); end
        n_checks++; if (out_class[7:0] !== 8'h14 || out_exp[10:0] !== 11'h0FF) begin
            n_fail++; $display("FAIL sgl_class: got %h %h want 14 0ff", out_class[7:0], out_exp[10:0]); end
        n_checks++; if (out_invalid !== 1'b1 || out_inf !== 1'b0 || out_precision !== 2'b10) begin
            n_fail++; $display("FAIL sgl_flags: got inv=%b inf=%b p=%b want 1 0 10", out_invalid, out_inf, out_precision); end
        @(posedge clk); #1 exp_ops++;
    endtask

    task automatic test_special;
        // {a, b, c, invalid, inf, inf_sign}
        logic [50:0] vec [6] = '{
            {16'h7C00, 16'h3C00, 16'hFC00, 3'b100},
            {16'h7C00, 16'h3C00, 16'h7C00, 3'b010},
            {16'hFC00, 16'h3C00, 16'h0000, 3'b011},
            {16'h7E00, 16'h3C00, 16'h0000, 3'b100},
            {16'h3C00, 16'h3C00, 16'hFC00, 3'b011},
            {16'h0000, 16'h7C00, 16'h3C00, 3'b100}};
        int n;
        for (int i = 0; i < 6; i++) begin
            send({48'd0, vec[i][50:35]}, {48'd0, vec[i][34:19]}, {48'd0, vec[i][18:3]}, 2'b01);
            wait_valid(n);
            n_checks++; if (n != 4 || {out_invalid, out_inf, out_inf_sign} !== vec[i][2:0]) begin
                n_fail++; $display("FAIL half_flags[%0d]: got lat=%0d flags=%b want 4 %b", i, n, {out_invalid, out_inf, out_inf_sign}, vec[i][2:0]); end
            @(posedge clk); #1 exp_ops++;
        end
        send(64'h7FF0000000000000, 64'h3FF0000000000000, 64'h0, 2'b11);
        wait_valid(n);
        n_checks++; if ({out_invalid, out_inf, out_inf_sign} !== 3'b010 || out_precision !== 2'b11) begin
            n_fail++; $display("FAIL prec11: got flags=%b p=%b want 010 11", {out_invalid, out_inf, out_inf_sign}, out_precision); end
        @(posedge clk); #1 exp_ops++;
    endtask

    task automatic test_back_to_back;
        int n;
        logic held;
        out_ready = 0;
        send(64'h3FF0000000000000, 64'h4000000000000000, 64'h0, 2'b00);
        wait_valid(n);
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL bp_latency: got %0d want 4", n); end
        in_valid = 1; op_a = 64'h4008000000000000; op_b = 64'hC000000000000000; op_c = 64'h3FF0000000000000;
        held = 1;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_exp !== {11'h000, 11'h400, 11'h3FF} || out_sign !== 3'b000) held = 0;
        end
        n_checks++; if (!held) begin n_fail++; $display("FAIL bp_hold: got v=%b r=%b exp=%h want 1 0 %h", out_valid, in_ready, out_exp, {11'h000, 11'h400, 11'h3FF}); end
        out_ready = 1;
        @(posedge clk); #1 exp_ops++;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || ops_issued !== exp_ops) begin
            n_fail++; $display("FAIL bp_handoff: got v=%b r=%b ops=%h want 0 1 %h", out_valid, in_ready, ops_issued, exp_ops); end
        @(posedge clk); #1 in_valid = 0;
        n_checks++; if (in_ready !== 1'b0 || dec_en !== 1'b1 || dec_in !== 64'h4008000000000000) begin
            n_fail++; $display("FAIL bp_next_accept: got r=%b en=%b in=%h want 0 1 4008000000000000", in_ready, dec_en, dec_in); end
        wait_valid(n);
        n_checks++; if (n != 4 || out_exp !== {11'h3FF, 11'h400, 11'h400} || out_sign !== 3'b010) begin
            n_fail++; $display("FAIL bp_second: got lat=%0d exp=%h sign=%b want 4 %h 010", n, out_exp, out_sign, {11'h3FF, 11'h400, 11'h400}); end
        @(posedge clk); #1 exp_ops++;
    endtask

    task automatic test_reset_mid;
        int n;
        logic quiet;
        send(64'h3FF0000000000000, 64'h4000000000000000, 64'h0, 2'b00);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (dec_in !== 64'h4000000000000000) begin n_fail++; $display("FAIL mid_dec_b: got %h want 4000000000000000", dec_in); end
        #1 rst = 1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || dec_en !== 1'b0 || dec_in !== 64'h0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_rst_ctl: got v=%b en=%b in=%h r=%b want 0 0 0 1", out_valid, dec_en, dec_in, in_ready); end
        n_checks++; if (ops_issued !== 4'd0 || out_exp !== 33'd0 || out_class !== 12'd0 || out_precision !== 2'b00) begin
            n_fail++; $display("FAIL mid_rst_data: got ops=%h exp=%h cls=%h want 0 0 0", ops_issued, out_exp, out_class); end
        @(negedge clk) rst = 0;
        exp_ops = 0;
        quiet = 1;
        repeat (6) @(negedge clk) if (out_valid !== 1'b0) quiet = 0;
        n_checks++; if (!quiet) begin n_fail++; $display("FAIL mid_no_partial: got out_valid=1 want 0"); end
        send(64'h3FF0000000000000, 64'h4000000000000000, 64'h0, 2'b00);
        wait_valid(n);
        n_checks++; if (n != 4 || out_exp !== {11'h000, 11'h400, 11'h3FF}) begin
            n_fail++; $display("FAIL mid_fresh: got lat=%0d exp=%h want 4 %h", n, out_exp, {11'h000, 11'h400, 11'h3FF}); end
        @(posedge clk); #1 exp_ops++;
        n_checks++; if (ops_issued !== 4'd1) begin n_fail++; $display("FAIL mid_ops: got %h want 1", ops_issued); end
    endtask

    task automatic test_wrap;
        int n;
        for (int i = 0; i < 15; i++) begin
            send(64'h3C00, 64'h3C00, 64'h0, 2'b01);
            wait_valid(n);
            @(posedge clk); #1 exp_ops++;
            if (i == 13) begin
                n_checks++; if (ops_issued !== 4'hF) begin n_fail++; $display("FAIL wrap_ones: got %h want f", ops_issued); end
            end
        end
        n_checks++; if (ops_issued !== 4'h0 || exp_ops !== 4'h0) begin n_fail++; $display("FAIL wrap_zero: got %h want 0", ops_issued); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_double;
        test_single;
        test_special;
        test_back_to_back;
        test_reset_mid;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
